crc4_gen: RTL and testbench
===========================

# crc4_gen

Serial CRC-4 generator: the transmit-side counterpart of the combinational CRC-4 checker in the ALU model. It accepts a WDATA-bit data word and a 4-bit generator polynomial over a valid/ready handshake, and shifts the word MSB-first through a 4-bit LFSR, one bit per clock. It then presents the 4-bit remainder and the systematic codeword {data, crc}. Any codeword it produces, when fed to the checker with the same polynomial, yields a zero remainder.

## Interface
- WDATA, 4, data word width in bits; legal range 1..32.
- i_clk  in  1  clock; all state changes on the rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_valid  in  1  upstream request; a word is offered this cycle.
- i_data  in  WDATA  data word, bit WDATA-1 processed first.
- i_poly  in  4  generator polynomial coefficients x^3..x^0; the x^4 term is implicit.
- o_ready  out  1  block can accept a word this cycle.
- o_valid  out  1  result available.
- i_ready  in  1  downstream consumes the result when o_valid is high.
- o_crc  out  4  CRC remainder of i_data·x^4 mod P.
- o_code  out  WDATA+4  codeword {data, crc}.

## Operation
- States:
  - IDLE: o_ready=1.
  - SHIFT: serial computation.
  - DONE: o_valid=1.
- Accept occurs on an edge where state=IDLE and i_valid=1.
  - On accept, register i_data into the shift register and i_poly into the poly register.
  - Clear the remainder r to 4'h0 and the bit counter to 0.
  - Go to SHIFT.
  - i_data and i_poly are don't-care after the accept edge.
- In IDLE with i_valid=0: hold the state; no register changes.
- SHIFT, each edge:
  - d = MSB of the shift register; fb = r[3] ^ d.
  - r <= {r[2:0],1'b0} ^ (fb ? poly : 4'h0).
  - Shift register <= shift register << 1; counter++.
- After WDATA shift edges, the state goes to DONE.
  - The counter is $clog2(WDATA)+1 bits wide so that WDATA=1 works.
- DONE: o_crc=r and o_code={original data, r}.
  - The original data is held in a separate register captured at accept.
  - Both outputs stay stable while o_valid=1.
- DONE with i_ready=1: transfer completes; go to IDLE on that edge.
- DONE with i_ready=0: hold indefinitely; outputs stay unchanged.
- o_ready is high only in IDLE, so no new word is accepted in SHIFT or DONE; i_valid there is ignored.
- Polynomial 4'h0 is legal: it yields crc=0 for all data.
- All arithmetic is GF(2) XOR; no carries.

## Timing
- Reset (i_rst=1 at an edge) puts the state in IDLE and sets all registers to 0.
  - Resulting outputs: o_ready=1, o_valid=0, o_crc=4'h0, o_code=0.
- Reset dominates i_valid and i_ready on the same edge.
- Reset in SHIFT or DONE aborts the word with no result emitted.
- Latency: accept at edge T means o_valid is high from edge T+WDATA onward. For WDATA=4, o_valid rises 4 cycles after the accept edge.
- Consume edge U returns the block to IDLE; o_ready is high after U; the earliest next accept is edge U+1.
- Peak throughput: one word per WDATA+2 cycles.
- All outputs are registered or decoded from the state only; there is no combinational path from any input to any output.

## Test plan
- Reset: hold i_rst for 2 cycles with i_valid=1 -> o_ready=1, o_valid=0, o_crc=0, o_code=0, and no accept occurs.
- Basic vector, WDATA=4, poly 4'h3 (x^4+x+1), data 4'hD -> o_valid 4 cycles after accept, o_crc=4'h4, o_code=8'hD4. Expected intermediate r after each edge: 3, 5, A, 4.
- Second vector, data 4'h8, poly 4'h3 -> o_crc=4'hB, o_code=8'h8B. Data 4'h0 with any poly -> o_crc=0.
- Backpressure: hold i_ready=0 for 10 cycles in DONE -> o_valid and o_code stay stable. Toggle i_valid and i_data during SHIFT and DONE -> result unchanged and no second accept. Raise i_ready -> IDLE on the next cycle.
- Reset mid-SHIFT on the 2nd shift edge -> IDLE, o_valid never asserts. Next word 4'hD with poly 3 -> correct 4'h4.
- Cross-check loop: drive random data and poly for 1000 words and feed each o_code into the CRC-4 checker with the same polynomial -> remainder 0 every time. Compare each o_crc against a reference model.

Source files
------------

// File: rtl/crc4_gen.sv
// Serial CRC-4 generator with valid/ready handshakes.
// Shifts one data bit per clock through a 4-bit LFSR, then holds {data, crc}.
module crc4_gen #(
  parameter int WDATA = 4
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_valid,
  input  logic [WDATA-1:0]   i_data,
  input  logic [3:0]         i_poly,
  output logic               o_ready,
  output logic               o_valid,
  input  logic               i_ready,
  output logic [3:0]         o_crc,
  output logic [WDATA+3:0]   o_code
);

  localparam int CW = $clog2(WDATA) + 1;
  localparam logic [CW-1:0] LAST = CW'(WDATA - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           r_state;
  logic [WDATA-1:0] r_shift;
  logic [WDATA-1:0] r_data;
  logic [3:0]       r_poly;
  logic [3:0]       r_crc;
  logic [CW-1:0]    r_cnt;

  logic             w_fb;
  logic [3:0]       w_next;

  // LFSR feedback: remainder MSB xor the incoming data bit.
  assign w_fb   = r_crc[3] ^ r_shift[WDATA-1];
  assign w_next = {r_crc[2:0], 1'b0} ^ (w_fb ? r_poly : 4'h0);

  // Handshake and result outputs decode only from registered state.
  assign o_ready = (r_state == S_IDLE);
  assign o_valid = (r_state == S_DONE);
  assign o_crc   = r_crc;
  assign o_code  = {r_data, r_crc};

  // Accept, shift one bit per cycle, then hold the result until consumed.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_shift <= '0;
      r_data  <= '0;
      r_poly  <= 4'h0;
      r_crc   <= 4'h0;
      r_cnt   <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (i_valid) begin
            r_shift <= i_data;
            r_data  <= i_data;
            r_poly  <= i_poly;
            r_crc   <= 4'h0;
            r_cnt   <= '0;
            r_state <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          r_crc   <= w_next;
          r_shift <= r_shift << 1;
          r_cnt   <= r_cnt + 1'b1;
          if (r_cnt == LAST) begin
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          if (i_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_crc4_gen.sv
// Self-checking bench for crc4_gen (WDATA=4).
// Scoreboard queue of expected results, long-division reference and checker.
module tb_crc4_gen;

  localparam int W = 4;

  logic           i_clk = 1'b0;
  logic           i_rst;
  logic           i_valid;
  logic [W-1:0]   i_data;
  logic [3:0]     i_poly;
  logic           o_ready;
  logic           o_valid;
  logic           i_ready;
  logic [3:0]     o_crc;
  logic [W+3:0]   o_code;

  int n_assert = 0;
  int n_fail   = 0;

  // expected entry: {crc, code}
  logic [W+7:0] sb [$];

  crc4_gen #(.WDATA(W)) dut (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_valid (i_valid),
    .i_data  (i_data),
    .i_poly  (i_poly),
    .o_ready (o_ready),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_crc   (o_crc),
    .o_code  (o_code)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Polynomial long division: remainder of v (nbits wide) mod x^4+p.
  function automatic logic [3:0] polymod(input logic [63:0] v,
                                         input int nbits,
                                         input logic [3:0] p);
    logic [3:0] r;
    logic [4:0] t;
    r = 4'h0;
    for (int i = nbits - 1; i >= 0; i--) begin
      t = {r, v[i]};
      if (t[4]) t = t ^ {1'b1, p};
      r = t[3:0];
    end
    return r;
  endfunction

  function automatic logic [3:0] ref_crc(input logic [W-1:0] d,
                                         input logic [3:0] p);
    logic [63:0] v;
    v = 64'({d, 4'h0});
    return polymod(v, W + 4, p);
  endfunction

  task automatic step;
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Offer one word; returns #1 after the accept edge.
  task automatic send(input logic [W-1:0] d, input logic [3:0] p);
    int n;
    logic [3:0] c;
    n = 0;
    while (!o_ready && n < 50) begin
      step;
      n++;
    end
    chk("send_ready", 32'(o_ready), 32'd1);
    c = ref_crc(d, p);
    i_valid = 1'b1;
    i_data  = d;
    i_poly  = p;
    sb.push_back({c, d, c});
    step;
    i_valid = 1'b0;
    i_data  = W'($urandom);
    i_poly  = 4'($urandom);
  endtask

  // Wait for a result, compare against scoreboard and checker, consume it.
  task automatic recv(input logic [3:0] p);
    int n;
    logic [W+7:0] e;
    n = 0;
    while (!o_valid && n < 50) begin
      step;
      n++;
    end
    chk("recv_valid", 32'(o_valid), 32'd1);
    chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk("crc", 32'(o_crc), 32'(e[W+7:W+4]));
      chk("code", 32'(o_code), 32'(e[W+3:0]));
      chk("check_zero", 32'(polymod(64'(o_code), W + 4, p)), 32'd0);
    end
    i_ready = 1'b1;
    step;
    i_ready = 1'b0;
    chk("consume_valid_low", 32'(o_valid), 32'd0);
    chk("consume_ready", 32'(o_ready), 32'd1);
  endtask

  initial begin
    logic [3:0] exp_r [4];
    logic [W+3:0] held;
    logic [W-1:0] d;
    logic [3:0] p;
    int k;
    exp_r[0] = 4'h3;
    exp_r[1] = 4'h5;
    exp_r[2] = 4'hA;
    exp_r[3] = 4'h4;

    // reset with i_valid high
    i_rst   = 1'b1;
    i_valid = 1'b1;
    i_data  = 4'hF;
    i_poly  = 4'h3;
    i_ready = 1'b0;
    step;
    step;
    chk("rst_ready", 32'(o_ready), 32'd1);
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_crc", 32'(o_crc), 32'd0);
    chk("rst_code", 32'(o_code), 32'd0);
    i_rst   = 1'b0;
    i_valid = 1'b0;
    step;
    chk("rst_no_accept", 32'(o_ready), 32'd1);

    // basic vector with intermediate remainders and latency
    send(4'hD, 4'h3);
    for (int j = 0; j < 4; j++) begin
      chk("basic_valid_low", 32'(o_valid), 32'd0);
      step;
      chk("basic_r", 32'(dut.r_crc), 32'(exp_r[j]));
    end
    chk("basic_latency", 32'(o_valid), 32'd1);
    chk("basic_crc", 32'(o_crc), 32'h4);
    chk("basic_code", 32'(o_code), 32'hD4);
    recv(4'h3);

    // second vector, zero data, zero polynomial
    send(4'h8, 4'h3);
    chk("vec8_expect", 32'(sb[0][W+3:0]), 32'h8B);
    recv(4'h3);
    send(4'h0, 4'h9);
    recv(4'h9);
    send(4'hB, 4'h0);
    recv(4'h0);

    // backpressure with input noise during SHIFT and DONE
    send(4'h8, 4'h3);
    k = 0;
    while (!o_valid && k < 50) begin
      i_valid = $urandom_range(0, 1);
      i_data  = W'($urandom);
      i_poly  = 4'($urandom);
      step;
      k++;
    end
    held = o_code;
    chk("bp_code", 32'(held), 32'h8B);
    for (int j = 0; j < 10; j++) begin
      i_valid = ~i_valid;
      i_data  = W'($urandom);
      step;
      chk("bp_valid", 32'(o_valid), 32'd1);
      chk("bp_ready", 32'(o_ready), 32'd0);
      chk("bp_stable", 32'(o_code), 32'(held));
    end
    i_valid = 1'b0;
    recv(4'h3);
    chk("bp_single", 32'(sb.size()), 32'd0);

    // reset on the 2nd shift edge aborts the word
    send(4'hD, 4'h3);
    step;
    i_rst = 1'b1;
    step;
    i_rst = 1'b0;
    void'(sb.pop_back());
    chk("abort_ready", 32'(o_ready), 32'd1);
    k = 0;
    for (int j = 0; j < 6; j++) begin
      step;
      if (o_valid) k++;
    end
    chk("abort_no_valid", 32'(k), 32'd0);
    send(4'hD, 4'h3);
    recv(4'h3);

    // random cross-check
    for (int j = 0; j < 1000; j++) begin
      d = W'($urandom);
      p = 4'($urandom);
      send(d, p);
      repeat ($urandom_range(3, 6)) step;
      recv(p);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
